// File: rtl/fifo_ram_ctrl.sv
// FIFO controller over an external single-port RAM with a registered read port.
// A 2-entry output buffer hides the RAM read latency from the consumer.
// Writes to the RAM take priority once a producer has been stalled by a read.
module fifo_ram_ctrl #(
    parameter int unsigned Data_width = 32,
    parameter int unsigned Addr_width = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_valid,
    output logic                  push_ready,
    input  logic [Data_width-1:0] push_data,
    output logic                  pop_valid,
    input  logic                  pop_ready,
    output logic [Data_width-1:0] pop_data,
    output logic [Addr_width:0]   count,
    output logic                  ram_we,
    output logic [Addr_width-1:0] ram_address,
    output logic [Data_width-1:0] ram_d,
    input  logic [Data_width-1:0] ram_q
);

    localparam int unsigned CW    = Addr_width + 1;
    localparam int unsigned DEPTH = 2 ** Addr_width;
    localparam logic [CW-1:0] RAM_FULL = CW'(DEPTH);

    logic [Addr_width-1:0] wr_ptr_q, wr_ptr_d;
    logic [Addr_width-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         ram_count_q, ram_count_d;
    logic [CW-1:0]         count_q, count_d;
    logic [Data_width-1:0] ob_data_q [2];
    logic [Data_width-1:0] ob_data_d [2];
    logic                  ob_head_q, ob_head_d;
    logic [1:0]            ob_count_q, ob_count_d;
    logic                  rd_inflight_q, rd_inflight_d;
    logic                  wr_prio_q, wr_prio_d;

    logic rd_issue;
    logic push_acc;
    logic pop_acc;
    logic ob_tail;

    // Handshake and RAM port decode; read issue depends on registered state only
    always_comb begin
        rd_issue    = (ram_count_q != '0)
                   && ((ob_count_q + 2'(rd_inflight_q)) < 2'd2)
                   && !wr_prio_q;
        push_ready  = (ram_count_q < RAM_FULL) && !rd_issue;
        push_acc    = push_valid && push_ready && rst_n;
        pop_valid   = (ob_count_q != 2'd0);
        pop_acc     = pop_valid && pop_ready;
        pop_data    = ob_data_q[ob_head_q];
        ob_tail     = ob_head_q ^ ob_count_q[0];
        count       = count_q;
        ram_we      = push_acc;
        ram_address = push_acc ? wr_ptr_q : rd_ptr_q;
        ram_d       = push_data;
    end

    // Next-state for pointers, occupancy, output buffer and write priority
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        ram_count_d   = ram_count_q;
        count_d       = count_q;
        ob_data_d     = ob_data_q;
        ob_head_d     = ob_head_q;
        ob_count_d    = ob_count_q;
        rd_inflight_d = rd_issue;
        wr_prio_d     = wr_prio_q;

        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + Addr_width'(1);
        end
        if (rd_issue) begin
            rd_ptr_d = rd_ptr_q + Addr_width'(1);
        end
        ram_count_d = ram_count_q + CW'(push_acc) - CW'(rd_issue);
        count_d     = count_q + CW'(push_acc) - CW'(pop_acc);

        // RAM data returning from last cycle's read lands behind any held word
        if (rd_inflight_q) begin
            ob_data_d[ob_tail] = ram_q;
        end
        ob_count_d = ob_count_q + 2'(rd_inflight_q) - 2'(pop_acc);
        ob_head_d  = ob_head_q ^ pop_acc;

        // A producer stalled by a read gets the next slot
        if (!push_valid || push_acc) begin
            wr_prio_d = 1'b0;
        end else if ((ram_count_q < RAM_FULL) && rd_issue) begin
            wr_prio_d = 1'b1;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            ram_count_q   <= '0;
            count_q       <= '0;
            ob_data_q[0]  <= '0;
            ob_data_q[1]  <= '0;
            ob_head_q     <= 1'b0;
            ob_count_q    <= 2'd0;
            rd_inflight_q <= 1'b0;
            wr_prio_q     <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            ram_count_q   <= ram_count_d;
            count_q       <= count_d;
            ob_data_q     <= ob_data_d;
            ob_head_q     <= ob_head_d;
            ob_count_q    <= ob_count_d;
            rd_inflight_q <= rd_inflight_d;
            wr_prio_q     <= wr_prio_d;
        end
    end

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Bench for fifo_ram_ctrl: behavioural registered-read RAM plus a queue scoreboard.
module tb_fifo_ram_ctrl;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 7;

    logic          clk;
    logic          rst_n;
    logic          push_valid;
    logic          push_ready;
    logic [DW-1:0] push_data;
    logic          pop_valid;
    logic          pop_ready;
    logic [DW-1:0] pop_data;
    logic [AW:0]   count;
    logic          ram_we;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_d;
    logic [DW-1:0] ram_q;

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] exp_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    fifo_ram_ctrl #(.Data_width(DW), .Addr_width(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
        .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
        .count(count),
        .ram_we(ram_we), .ram_address(ram_address), .ram_d(ram_d), .ram_q(ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM with registered read data
    always @(posedge clk) begin
        if (ram_we) mem[ram_address] <= ram_d;
        ram_q <= mem[ram_address];
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: count tracks queue depth; pops compared, accepted pushes enqueued
    always @(negedge clk) begin
        if (rst_n) begin
            check_eq("count", 64'(count), 64'(exp_q.size()));
            if (pop_valid && pop_ready) begin
                if (exp_q.size() == 0) check_eq("pop_underflow", 64'(exp_q.size()), 64'd1);
                else check_eq("pop_data", 64'(pop_data), 64'(exp_q.pop_front()));
            end
            if (push_valid && push_ready) exp_q.push_back(push_data);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one word, leave push_valid high afterwards; reports cycles spent waiting
    task automatic push_word(input logic [DW-1:0] d, output int waited);
        push_valid = 1'b1;
        push_data  = d;
        waited     = 0;
        forever begin
            @(negedge clk);
            if (push_ready) break;
            waited++;
            if (waited > 50) begin
                check_eq("push_timeout", 64'(waited), 64'd0);
                break;
            end
            step();
        end
        step();
    endtask

    task automatic drain(input int budget);
        push_valid = 1'b0;
        pop_ready  = 1'b1;
        for (int n = 0; n < budget && exp_q.size() != 0; n++) step();
        step();
        check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
        check_eq("drain_pop_valid", 64'(pop_valid), 64'd0);
        check_eq("drain_count", 64'(count), 64'd0);
    endtask

    // Single push into an empty controller: pop_valid rises after the second following edge
    task automatic latency_check(input logic [DW-1:0] d);
        pop_ready  = 1'b0;
        push_valid = 1'b1;
        push_data  = d;
        @(negedge clk);
        check_eq("lat_ready", 64'(push_ready), 64'd1);
        step();
        push_valid = 1'b0;
        check_eq("lat_e1_valid", 64'(pop_valid), 64'd0);
        check_eq("lat_e1_count", 64'(count), 64'd1);
        step();
        check_eq("lat_e2_valid", 64'(pop_valid), 64'd0);
        step();
        check_eq("lat_e3_valid", 64'(pop_valid), 64'd1);
        check_eq("lat_e3_data", 64'(pop_data), 64'(d));
        check_eq("lat_e3_count", 64'(count), 64'd1);
    endtask

    initial begin
        int w;
        int max_wait;
        bit found;

        // Reset outputs with a push offered during reset
        rst_n      = 1'b0;
        push_valid = 1'b1;
        push_data  = 32'hDEAD_BEEF;
        pop_ready  = 1'b1;
        #12;
        check_eq("rst_pop_valid", 64'(pop_valid), 64'd0);
        check_eq("rst_ram_we", 64'(ram_we), 64'd0);
        check_eq("rst_push_ready", 64'(push_ready), 64'd1);
        check_eq("rst_count", 64'(count), 64'd0);
        push_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();

        latency_check(32'hA0A0_0000);
        drain(20);

        // Fill to 130, confirm backpressure, then drain in order
        pop_ready = 1'b0;
        for (int i = 0; i < 130; i++) push_word(DW'(i), w);
        push_data = 32'h0000_0999;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("full_push_ready", 64'(push_ready), 64'd0);
            check_eq("full_count", 64'(count), 64'd130);
            step();
        end
        drain(400);

        // Continuous streaming across two pointer wraps
        pop_ready = 1'b1;
        max_wait  = 0;
        for (int i = 0; i < 300; i++) begin
            push_word(DW'(1000 + i), w);
            if (w > max_wait) max_wait = w;
        end
        check_eq("stream_max_wait", 64'(max_wait <= 2), 64'd1);
        drain(400);

        // Output buffer full and consumer stalled: every cycle is a write
        pop_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(DW'(2000 + i), w);
        push_valid = 1'b0;
        repeat (4) step();
        push_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            push_data = DW'(5000 + k);
            @(negedge clk);
            check_eq("obfull_ram_we", 64'(ram_we), 64'd1);
            step();
        end
        drain(100);

        // Asynchronous reset with a read in flight and a word buffered
        pop_ready  = 1'b0;
        push_valid = 1'b1;
        push_data  = 32'h0000_7000;
        found      = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk);
            if (!ram_we && pop_valid) found = 1'b1;
            @(posedge clk);
            #1;
            push_data = push_data + 32'd1;
        end
        check_eq("inflight_setup", 64'(found), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check_eq("async_pop_valid", 64'(pop_valid), 64'd0);
        check_eq("async_ram_we", 64'(ram_we), 64'd0);
        check_eq("async_push_ready", 64'(push_ready), 64'd1);
        check_eq("async_count", 64'(count), 64'd0);
        push_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_eq("post_rst_count", 64'(count), 64'd0);
        latency_check(32'hB0B0_0001);
        drain(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_ram_ctrl.md
FIFO_RAM_CTRL -- requirements
Module: fifo_ram_ctrl

Interface
REQ-001 SHALL have parameter Data_width, default 32, word width in bits.
REQ-002 SHALL have parameter Addr_width, default 7, RAM address width; RAM depth is 2**Addr_width (128).
REQ-003 SHALL have one clock; reset is asynchronous and active-low; ports named clk and rst_n.
REQ-004 clk  input  1  rising-edge clock, shared with the attached RAM.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 push_valid  input  1  producer offers push_data.
REQ-007 push_ready  output  1  controller accepts push this cycle.
REQ-008 push_data  input  Data_width  word to enqueue.
REQ-009 pop_valid  output  1  pop_data holds the oldest word.
REQ-010 pop_ready  input  1  consumer takes pop_data.
REQ-011 pop_data  output  Data_width  head word.
REQ-012 count  output  Addr_width+1  total words held (RAM + in-flight + output buffer), max 130.
REQ-013 ram_we  output  1  RAM write enable.
REQ-014 ram_address  output  Addr_width  RAM address, single port.
REQ-015 ram_d  output  Data_width  RAM write data.
REQ-016 ram_q  input  Data_width  RAM read data, registered, valid one cycle after the read-address edge.

Function
REQ-017 SHALL keep wr_ptr, rd_ptr (Addr_width bits, wrap 127->0) and ram_count (0..128).
REQ-018 SHALL hold a 2-entry output buffer (ob) plus a 1-bit rd_inflight flag; pop_data = ob head, pop_valid = ob nonempty.
REQ-019 rd_issue SHALL be 1 when ram_count>0, ob_count+rd_inflight<2, and wr_prio=0; it depends on registered state only.
REQ-020 push_ready SHALL be 1 when ram_count<128 and rd_issue=0; it does not depend on push_valid.
REQ-021 Push acceptance (push_valid and push_ready): ram_we=1, ram_address=wr_ptr, ram_d=push_data, wr_ptr+1, ram_count+1.
REQ-022 On rd_issue: ram_we=0, ram_address=rd_ptr, rd_ptr+1, ram_count-1, rd_inflight set for the next cycle.
REQ-023 When neither occurs: ram_we=0, ram_address=rd_ptr.
REQ-024 When rd_inflight=1, ram_q SHALL be written into the ob tail at the next edge.
REQ-025 Pop (pop_valid and pop_ready) SHALL remove the ob head at the edge; a same-cycle pop and ob capture SHALL both take effect.
REQ-026 wr_prio SHALL set at an edge where push_valid=1, ram_count<128 and rd_issue=1; it SHALL clear on push acceptance or when push_valid=0.
REQ-027 Latency: a push accepted at edge N into an empty controller SHALL raise pop_valid after edge N+2.
REQ-028 Full: ram_count=128 forces push_ready=0; the producer SHALL see no data loss.
REQ-029 Empty: pop_valid=0 and pop_data is don't-care; pop_ready is ignored.
REQ-030 count SHALL update on the same edge as every push or pop, with no read-issue effect.
REQ-031 Word order at pop SHALL equal push order, including across pointer wrap.

Reset
REQ-032 rst_n=0 SHALL immediately clear wr_ptr, rd_ptr, ram_count, ob_count, rd_inflight, wr_prio and count.
REQ-033 During reset pop_valid=0, ram_we=0 and push_ready=1, independent of clk.
REQ-034 Reset mid-operation SHALL discard all stored, in-flight and buffered words; RAM contents are not cleared.

Verification
REQ-035 Reset, then push A0 at edge 1 with pop_ready=0 -> pop_valid=1 after edge 3 with pop_data=A0; count=1.
REQ-036 Push 130 words with pop_ready=0 -> the 131st push sees push_ready=0; count=130; then pop all -> data is in order 0..129.
REQ-037 Push and pop continuously for 300 words -> the output is in order, pointers wrap twice, and wr_prio prevents any push from waiting more than 2 cycles.
REQ-038 With ob full and pop_ready=0, hold push_valid=1 -> a write every cycle and no read until pop_ready rises.
REQ-039 Assert rst_n=0 asynchronously mid-burst with rd_inflight=1 -> outputs are reset before the next edge; after release count=0 and the next push follows REQ-027 timing.
